spi_txn_arbiter: RTL
====================

Name: spi_txn_arbiter

Overview:
- Shares the single SPI master between N_REQ bus-side requesters, e.g. the APB bridge plus a local sequencer.
- Round-robin arbitration; the winner's command (slave select, address, write data, direction) is latched and issued to the master as one transaction.
- Waits for completion or timeout, then returns read data and status to the granted requester.
- Sits between the APB-side logic and the spi_controller inside top.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- TIMEOUT, 1023, maximum cycles in WAIT before abort (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- req_write  in  N_REQ  1 = write, 0 = read.
- req_cs  in  2*N_REQ  target slave index 0..2 per requester; 3 = invalid.
- req_addr  in  8*N_REQ  SPI address per requester.
- req_wdata  in  8*N_REQ  write data per requester.
- gnt  out  N_REQ  one-hot grant.
- done  out  N_REQ  one-cycle completion pulse.
- err  out  1  error status, valid with done.
- rdata  out  8  read data, valid with done.
- busy  out  1  high whenever state != IDLE.
- m_start  out  1  one-cycle transaction start to the SPI master.
- m_write  out  1  direction to the master.
- m_addr  out  8  address to the master.
- m_data  out  8  write data to the master.
- m_cs  out  3  one-hot slave select to the master.
- m_abort  out  1  one-cycle abort to the master.
- m_done  in  1  master completion pulse.
- m_rdata  in  8  master read data, valid with m_done.

Behaviour:
- Reset (reset low, async): state IDLE, rr_ptr=0, all outputs 0 (gnt, done, err, rdata, busy, m_*). A reset mid-transaction abandons it; no done is issued.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE
  - If any req bit is set, pick the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Latch that requester's write/cs/addr/wdata, set gnt one-hot, go to ISSUE.
  - If the latched cs == 3, skip the master entirely: go to RESP with err=1, rdata=0.
- ISSUE (1 cycle)
  - m_start=1, m_cs=1<<cs, m_write/m_addr/m_data from the latches.
  - Timeout counter cleared. Go to WAIT.
- WAIT
  - m_start=0; m_addr/m_data/m_write/m_cs held stable; counter increments each cycle.
  - On m_done: capture m_rdata (rdata=0 on writes), err=0, go to RESP.
  - Else if counter == TIMEOUT: m_abort=1 for one cycle, err=1, rdata=0, go to RESP.
  - m_done and timeout in the same cycle: m_done wins, no abort.
- RESP (1 cycle)
  - done[granted]=1; err and rdata valid; m_cs cleared.
  - rr_ptr = (granted+1) mod N_REQ. Next cycle gnt=0, done=0, state IDLE.
- Latency:
  - req high in IDLE -> m_start asserted 2 cycles later.
  - m_done -> done asserted 1 cycle later.
  - Minimum back-to-back spacing is 1 IDLE cycle.
- Requester rule: hold req and operands stable until done. Request inputs are ignored outside IDLE. A req still high in the cycle after done counts as a new request.
- Fairness: with all requesters active, grants rotate 0,1,2,0,... so no requester waits more than N_REQ-1 transactions.
- m_done received outside WAIT is ignored.
- Timeout counter width is clog2(TIMEOUT+1) and it never wraps.

Decomposition:
- Package spi_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), CS_INVALID=2'd3, NUM_SLAVES=3, DATA_W=8, ADDR_W=8.
- One sub-module, spi_rr_pick: combinational round-robin selector (req, rr_ptr -> one-hot pick, index, any). Sequencing, latches and the timeout counter stay in spi_txn_arbiter.

Test Plan:
- Single write: req[0], cs=1, addr=8'h12, wdata=8'hA5; master returns m_done 20 cycles after start -> m_start 2 cycles after req, m_cs=3'b010, m_addr=8'h12, m_data=8'hA5, one done[0] pulse, err=0.
- Read: req[2], cs=2, addr=8'h40; m_done with m_rdata=8'h3C -> done[2] with rdata=8'h3C, m_cs=3'b100, m_write=0.
- Contention: req=3'b111 held continuously, rr_ptr=0 after reset -> grant order 0,1,2,0; each done matches the preceding gnt; no requester skipped.
- Timeout: TIMEOUT=15, master never returns m_done -> m_abort pulses exactly 15 cycles after entering WAIT, then done with err=1, rdata=0; a subsequent request completes normally.
- Invalid select: req[1] with cs=3 -> m_start never asserted, done[1] with err=1 within 2 cycles.
- Edge cases:
  - reset driven low during WAIT -> all outputs 0 immediately; after release, state IDLE and rr_ptr=0.
  - m_done coincident with the timeout cycle -> err=0, m_abort stays 0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] CS_INVALID = 2'd3;
  localparam int         NUM_SLAVES = 3;
  localparam int         DATA_W     = 8;
  localparam int         ADDR_W     = 8;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i,
// wrapping modulo N_REQ.
module spi_rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [2*N_REQ-1:0] rot;
  int                 pos;

  // Rotate the doubled request vector so offset 0 is ptr_i, then take the lowest offset.
  always_comb begin
    rot    = {req_i, req_i} >> ptr_i;
    pos    = 0;
    idx_o  = '0;
    pick_o = '0;
    any_o  = |req_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = int'(ptr_i) + k;
        if (pos >= N_REQ) begin
          pos = pos - N_REQ;
        end else begin
          pos = pos;
        end
        idx_o = IDX_W'(pos);
      end else begin
        idx_o = idx_o;
      end
    end
    if (any_o) begin
      pick_o = {{(N_REQ-1){1'b0}}, 1'b1} << idx_o;
    end else begin
      pick_o = '0;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters; issues
// one transaction at a time and returns status/read data to the winner.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [2*N_REQ-1:0]      req_cs,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  input  logic [DATA_W*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    err,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic                    m_start,
  output logic                    m_write,
  output logic [ADDR_W-1:0]       m_addr,
  output logic [DATA_W-1:0]       m_data,
  output logic [NUM_SLAVES-1:0]   m_cs,
  output logic                    m_abort,
  input  logic                    m_done,
  input  logic [DATA_W-1:0]       m_rdata
);

  localparam int               IDX_W     = $clog2(N_REQ);
  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic                  wr_q, wr_d;
  logic [1:0]            cs_q, cs_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [N_REQ-1:0]      done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  m_start_q, m_start_d;
  logic                  m_write_q, m_write_d;
  logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
  logic [DATA_W-1:0]     m_data_q, m_data_d;
  logic [NUM_SLAVES-1:0] m_cs_q, m_cs_d;
  logic                  m_abort_q, m_abort_d;

  logic [N_REQ-1:0]      pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;

  spi_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .pick_o (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Counter value after this WAIT cycle; abort fires when it reaches TIMEOUT,
  // so m_abort rises exactly TIMEOUT cycles after m_start.
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gidx_d    = gidx_q;
    wr_d      = wr_q;
    cs_d      = cs_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    m_start_d = 1'b0;
    m_abort_d = 1'b0;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    m_cs_d    = m_cs_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = ISSUE;
          gidx_d  = pick_idx;
          gnt_d   = pick_oh;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
              wr_d    = req_write[i];
              cs_d    = req_cs[2*i +: 2];
              addr_d  = req_addr[ADDR_W*i +: ADDR_W];
              wdata_d = req_wdata[DATA_W*i +: DATA_W];
            end else begin
              wr_d = wr_d;
            end
          end
        end else begin
          gnt_d = '0;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (cs_q == CS_INVALID) begin
          state_d = RESP;
          done_d  = gnt_q;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d   = WAIT;
          m_start_d = 1'b1;
          m_write_d = wr_q;
          m_addr_d  = addr_q;
          m_data_d  = wdata_q;
          m_cs_d    = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << cs_q;
        end
      end
      WAIT: begin
        if (m_done) begin
          state_d = RESP;
          done_d  = gnt_q;
          err_d   = 1'b0;
          rdata_d = wr_q ? '0 : m_rdata;
          m_cs_d  = '0;
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d   = RESP;
          done_d    = gnt_q;
          err_d     = 1'b1;
          rdata_d   = '0;
          m_abort_d = 1'b1;
          m_cs_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        state_d  = IDLE;
        gnt_d    = '0;
        err_d    = 1'b0;
        rdata_d  = '0;
        rr_ptr_d = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, latches and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gidx_q    <= '0;
      wr_q      <= 1'b0;
      cs_q      <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_cs_q    <= '0;
      m_abort_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gidx_q    <= gidx_d;
      wr_q      <= wr_d;
      cs_q      <= cs_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      m_start_q <= m_start_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      m_cs_q    <= m_cs_d;
      m_abort_q <= m_abort_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign m_start = m_start_q;
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_data  = m_data_q;
  assign m_cs    = m_cs_q;
  assign m_abort = m_abort_q;

endmodule
